// File: rtl/reflet_cpu_core_if.sv
// Memory bus between the Reflet core and its synchronous memory.
// Read data is valid the cycle after addr is presented.
interface reflet_cpu_core_if #(
  parameter int unsigned WORDSIZE = 8
);
  logic [WORDSIZE-1:0] addr;
  logic [WORDSIZE-1:0] data_out;
  logic [WORDSIZE-1:0] data_in;
  logic                write_en;

  modport master (
    output addr,
    output data_out,
    output write_en,
    input  data_in
  );

  modport slave (
    input  addr,
    input  data_out,
    input  write_en,
    output data_in
  );
endinterface

// File: rtl/reflet_cpu_core.sv
// Multi-cycle accumulator CPU: FETCH -> EXEC [-> MEM], with a one-cycle INT state
// that pushes PC and vectors to 4*(i+1) for edge-triggered external interrupts.
module reflet_cpu_core #(
  parameter int unsigned WORDSIZE = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  reflet_cpu_core_if.master mem,
  input  logic [3:0]        ext_int,
  output logic              quit,
  output logic              debug
);
  localparam int unsigned ShW = $clog2(WORDSIZE);

  typedef logic [WORDSIZE-1:0] word_t;
  typedef enum logic [2:0] {StFetch, StExec, StMem, StInt, StHalt} state_e;

  localparam word_t One = word_t'(1);

  state_e     state_q, state_d;
  word_t      regs_q [16];
  word_t      regs_d [16];
  logic [7:0] instr_q, instr_d;
  logic [3:0] ext_q, pending_q, pending_d, irq_hit, irq_clr;
  logic [1:0] irq_idx;
  logic       in_isr_q, in_isr_d, quit_q, quit_d, debug_q, debug_d;

  word_t      wr, sp, pc, rx, pc_next, addr, data_out;
  logic       write_en;
  logic [7:0] cur;
  logic [3:0] op, x;

  assign wr = regs_q[0];
  assign sp = regs_q[13];
  assign pc = regs_q[14];

  // EXEC decodes straight off the bus; MEM works from the latched copy.
  assign cur = (state_q == StExec) ? mem.data_in[7:0] : instr_q;
  assign op  = cur[7:4];
  assign x   = cur[3:0];
  assign rx  = regs_q[x];

  assign irq_hit = pending_q & regs_q[12][7:4];

  always_comb begin
    irq_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (irq_hit[i]) irq_idx = 2'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    regs_d   = regs_q;
    instr_d  = instr_q;
    in_isr_d = in_isr_q;
    quit_d   = quit_q;
    debug_d  = 1'b0;
    irq_clr  = '0;
    addr     = pc;
    data_out = '0;
    write_en = 1'b0;
    pc_next  = pc + One;

    unique case (state_q)
      StFetch: state_d = (!in_isr_q && |irq_hit) ? StInt : StExec;
      StInt: begin
        addr              = sp - One;
        data_out          = pc;
        write_en          = 1'b1;
        regs_d[13]        = sp - One;
        regs_d[14]        = word_t'({({1'b0, irq_idx} + 3'd1), 2'b00});
        irq_clr[irq_idx]  = 1'b1;
        in_isr_d          = 1'b1;
        state_d           = StFetch;
      end
      StExec: begin
        instr_d = cur;
        state_d = StFetch;
        unique case (op)
          4'h0: begin
            case (x)
              4'h1: if (regs_q[12][0]) pc_next = wr;
              4'h2: begin
                addr       = sp - One;
                data_out   = pc + One;
                write_en   = 1'b1;
                regs_d[13] = sp - One;
                pc_next    = wr;
              end
              4'h3, 4'h5, 4'h6: begin
                addr    = sp;
                pc_next = pc;
                state_d = StMem;
              end
              4'h4: begin
                addr       = sp - One;
                data_out   = wr;
                write_en   = 1'b1;
                regs_d[13] = sp - One;
              end
              4'h7: regs_d[12][0] = ~regs_q[12][0];
              4'h8: debug_d = 1'b1;
              4'h9: begin
                quit_d  = 1'b1;
                pc_next = pc;
                state_d = StHalt;
              end
              default: ;
            endcase
          end
          4'h1: regs_d[0] = word_t'(x);
          4'h2: regs_d[0] = rx;
          4'h3: if (x == 4'he) pc_next = wr; else regs_d[x] = wr;
          4'h4: regs_d[0] = wr + rx;
          4'h5: regs_d[0] = wr - rx;
          4'h6: regs_d[0] = wr & rx;
          4'h7: regs_d[0] = wr | rx;
          4'h8: regs_d[0] = wr ^ rx;
          4'h9: if (x == 4'he) pc_next = ~rx; else regs_d[x] = ~rx;
          4'ha: regs_d[0] = wr << rx[ShW-1:0];
          4'hb: regs_d[0] = wr >> rx[ShW-1:0];
          4'hc: regs_d[12][0] = (wr == rx);
          4'hd: regs_d[12][0] = (wr < rx);
          4'he: begin
            addr     = rx;
            data_out = wr;
            write_en = 1'b1;
          end
          4'hf: begin
            addr    = rx;
            pc_next = pc;
            state_d = StMem;
          end
        endcase
        regs_d[14] = pc_next;
      end
      StMem: begin
        state_d = StFetch;
        if (op == 4'hf) begin
          addr       = rx;
          regs_d[0]  = mem.data_in;
          regs_d[14] = pc + One;
        end else begin
          addr       = sp;
          regs_d[13] = sp + One;
          if (x == 4'h5) begin
            regs_d[0]  = mem.data_in;
            regs_d[14] = pc + One;
          end else begin
            regs_d[14] = mem.data_in;
            if (x == 4'h6) in_isr_d = 1'b0;
          end
        end
      end
      StHalt: ;
      default: state_d = StFetch;
    endcase

    // Frozen: hold everything; in EXEC keep PC on the bus so the instruction stays readable.
    if (!enable) begin
      state_d  = state_q;
      regs_d   = regs_q;
      instr_d  = instr_q;
      in_isr_d = in_isr_q;
      quit_d   = quit_q;
      irq_clr  = '0;
      debug_d  = 1'b0;
      write_en = 1'b0;
      if (state_q == StExec) addr = pc;
    end

    regs_d[15] = '0;
    pending_d  = (pending_q & ~irq_clr) | (ext_int & ~ext_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
      instr_q   <= '0;
      ext_q     <= '0;
      pending_q <= '0;
      in_isr_q  <= 1'b0;
      quit_q    <= 1'b0;
      debug_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      regs_q    <= regs_d;
      instr_q   <= instr_d;
      ext_q     <= ext_int;
      pending_q <= pending_d;
      in_isr_q  <= in_isr_d;
      quit_q    <= quit_d;
      debug_q   <= debug_d;
    end
  end

  assign mem.addr     = addr;
  assign mem.data_out = data_out;
  assign mem.write_en = write_en;
  assign quit         = quit_q;
  assign debug        = debug_q;
endmodule

// File: tb/tb_reflet_cpu_core.sv
// Bench for reflet_cpu_core: directed programs plus random programs checked against an
// instruction-level model of the ISA (registers, memory, write trace, cycle count).
module tb_reflet_cpu_core;
  localparam int unsigned W = 8;

  logic       clk = 1'b0;
  logic       reset, enable;
  logic [3:0] ext_int;
  logic       quit, debug;

  reflet_cpu_core_if #(.WORDSIZE(W)) mem_if ();

  reflet_cpu_core #(.WORDSIZE(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .mem    (mem_if.master),
    .ext_int(ext_int),
    .quit   (quit),
    .debug  (debug)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [256];
  logic [7:0] img [256];
  logic       ram_load = 1'b0;

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 256; i++) ram[i] <= img[i];
      mem_if.data_in <= '0;
    end else begin
      if (mem_if.write_en) ram[mem_if.addr] <= mem_if.data_out;
      mem_if.data_in <= ram[mem_if.addr];
    end
  end

  logic [15:0] wlog [$];
  int          dbg_cnt, dbg_run, dbg_max;
  logic        mon_clr = 1'b1;

  always @(negedge clk) begin
    if (mon_clr) begin
      wlog.delete();
      dbg_cnt = 0; dbg_run = 0; dbg_max = 0;
    end else if (!reset) begin
      if (mem_if.write_en) wlog.push_back({mem_if.addr, mem_if.data_out});
      if (debug) begin
        dbg_run++;
        if (dbg_run == 1) dbg_cnt++;
        if (dbg_run > dbg_max) dbg_max = dbg_run;
      end else dbg_run = 0;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- instruction-level reference model ----------------
  logic [7:0]  m_mem [256];
  logic [7:0]  m_reg [16];
  logic [15:0] m_wlog [$];
  int          m_cycles, m_dbg, m_len;
  bit          m_quit, m_clean;

  task automatic m_write(input logic [7:0] a, input logic [7:0] d);
    m_mem[a] = d;
    m_wlog.push_back({a, d});
    if (int'(a) <= m_len) m_clean = 0;
  endtask

  task automatic m_push(input logic [7:0] v);
    m_reg[13] = m_reg[13] - 8'd1;
    m_write(m_reg[13], v);
  endtask

  task automatic m_pop(output logic [7:0] v);
    v = m_mem[m_reg[13]];
    m_reg[13] = m_reg[13] + 8'd1;
  endtask

  task automatic model_run();
    logic [7:0] ins, rx, npc, v;
    logic [3:0] op, x;
    for (int i = 0; i < 16; i++) m_reg[i] = 8'd0;
    m_wlog.delete();
    m_cycles = 0; m_dbg = 0; m_quit = 0; m_clean = 1;
    for (int n = 0; n < 500 && !m_quit; n++) begin
      ins = m_mem[m_reg[14]];
      op = ins[7:4]; x = ins[3:0];
      rx = (x == 4'hf) ? 8'd0 : m_reg[x];
      npc = m_reg[14] + 8'd1;
      m_cycles += 2;
      case (op)
        4'h0: case (x)
          4'h1: if (m_reg[12][0]) npc = m_reg[0];
          4'h2: begin m_push(npc); npc = m_reg[0]; end
          4'h3: begin m_pop(npc); m_cycles++; end
          4'h4: m_push(m_reg[0]);
          4'h5: begin m_pop(v); m_reg[0] = v; m_cycles++; end
          4'h6: begin m_pop(npc); m_cycles++; end
          4'h7: m_reg[12][0] = ~m_reg[12][0];
          4'h8: m_dbg++;
          4'h9: begin m_quit = 1; npc = m_reg[14]; end
          default: ;
        endcase
        4'h1: m_reg[0] = {4'h0, x};
        4'h2: m_reg[0] = rx;
        4'h3: if (x == 4'he) npc = m_reg[0]; else if (x != 4'hf) m_reg[x] = m_reg[0];
        4'h4: m_reg[0] = m_reg[0] + rx;
        4'h5: m_reg[0] = m_reg[0] - rx;
        4'h6: m_reg[0] = m_reg[0] & rx;
        4'h7: m_reg[0] = m_reg[0] | rx;
        4'h8: m_reg[0] = m_reg[0] ^ rx;
        4'h9: if (x == 4'he) npc = ~rx; else if (x != 4'hf) m_reg[x] = ~rx;
        4'ha: m_reg[0] = m_reg[0] << (rx % 8);
        4'hb: m_reg[0] = m_reg[0] >> (rx % 8);
        4'hc: m_reg[12][0] = (m_reg[0] == rx);
        4'hd: m_reg[12][0] = (m_reg[0] < rx);
        4'he: m_write(rx, m_reg[0]);
        4'hf: begin m_reg[0] = m_mem[rx]; m_cycles++; end
      endcase
      m_reg[14] = npc;
    end
    if (!m_quit) m_clean = 0;
  endtask

  // ---------------- helpers ----------------
  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
  endtask

  task automatic start_dut();
    enable = 1'b1; ext_int = 4'h0; reset = 1'b1; ram_load = 1'b1; mon_clr = 1'b1;
    @(posedge clk); #1 ram_load = 1'b0;
    @(negedge clk); #1 mon_clr = 1'b0; reset = 1'b0;
  endtask

  task automatic run_program(input string name, output int cyc);
    int nw;
    for (int i = 0; i < 256; i++) m_mem[i] = img[i];
    m_len = -1;
    model_run();
    start_dut();
    cyc = 0;
    while (cyc < 3000) begin
      @(posedge clk); #1 cyc++;
      if (quit) break;
    end
    n_assert++;
    if (cyc !== m_cycles || quit !== 1'b1)
      begin n_fail++; $display("FAIL %s quit_cycle: got %0d (quit=%b) want %0d", name, cyc, quit, m_cycles); end
    for (int r = 0; r < 14; r++) begin
      n_assert++;
      if (dut.regs_q[r] !== m_reg[r])
        begin n_fail++; $display("FAIL %s R%0d: got %h want %h", name, r, dut.regs_q[r], m_reg[r]); end
    end
    n_assert++;
    if (wlog.size() !== m_wlog.size())
      begin n_fail++; $display("FAIL %s write_count: got %0d want %0d", name, wlog.size(), m_wlog.size()); end
    else for (int i = 0; i < wlog.size(); i++) begin
      n_assert++;
      if (wlog[i] !== m_wlog[i])
        begin n_fail++; $display("FAIL %s write%0d: got %h want %h", name, i, wlog[i], m_wlog[i]); end
    end
    n_assert++;
    if (dbg_cnt !== m_dbg || (m_dbg > 0 && dbg_max !== 1))
      begin n_fail++; $display("FAIL %s debug: got %0d pulses max %0d want %0d x1", name, dbg_cnt, dbg_max, m_dbg); end
    nw = wlog.size();
    repeat (4) @(posedge clk);
    #1;
    n_assert++;
    if (quit !== 1'b1 || wlog.size() !== nw || mem_if.write_en !== 1'b0)
      begin n_fail++; $display("FAIL %s halt: quit %b writes %0d want 1 %0d", name, quit, wlog.size(), nw); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_img();
    img[0] = 8'h04; img[1] = 8'h09;
    start_dut();
    n_assert++;
    if (mem_if.addr !== 8'h00 || mem_if.write_en !== 1'b0 || quit !== 1'b0 || debug !== 1'b0)
      begin n_fail++; $display("FAIL reset_outputs: addr %h we %b quit %b dbg %b want 00 0 0 0",
                               mem_if.addr, mem_if.write_en, quit, debug); end
    @(negedge clk);
    n_assert++;
    if (mem_if.write_en !== 1'b1 || mem_if.addr !== 8'hff)
      begin n_fail++; $display("FAIL first_push: we %b addr %h want 1 ff", mem_if.write_en, mem_if.addr); end
    reset = 1'b1;
    #1;
    n_assert++;
    if (mem_if.write_en !== 1'b0 || mem_if.addr !== 8'h00)
      begin n_fail++; $display("FAIL reset_abort: we %b addr %h want 0 00", mem_if.write_en, mem_if.addr); end
    @(posedge clk); #1;
    n_assert++;
    if (ram[255] !== 8'h00)
      begin n_fail++; $display("FAIL aborted_write: ram[ff] %h want 00", ram[255]); end
  endtask

  task automatic test_arith();
    int cyc;
    clear_img();
    img[0] = 8'h15; img[1] = 8'h31; img[2] = 8'h13; img[3] = 8'h41; img[4] = 8'h09;
    run_program("arith", cyc);
    n_assert++;
    if (cyc !== 10 || dut.regs_q[0] !== 8'd8 || dut.regs_q[1] !== 8'd5 || wlog.size() !== 0)
      begin n_fail++; $display("FAIL arith_const: cyc %0d WR %h R1 %h writes %0d want 10 08 05 0",
                               cyc, dut.regs_q[0], dut.regs_q[1], wlog.size()); end
  endtask

  task automatic test_mem();
    int cyc;
    clear_img();
    img[0] = 8'h12; img[1] = 8'h32; img[2] = 8'h17; img[3] = 8'he2; img[4] = 8'hf2; img[5] = 8'h09;
    run_program("mem", cyc);
    n_assert++;
    if (cyc !== 13 || wlog.size() !== 1 || dut.regs_q[0] !== 8'd7)
      begin n_fail++; $display("FAIL mem_const: cyc %0d writes %0d WR %h want 13 1 07", cyc, wlog.size(), dut.regs_q[0]); end
    else begin
      n_assert++;
      if (wlog[0] !== 16'h0207) begin n_fail++; $display("FAIL mem_write: got %h want 0207", wlog[0]); end
    end
  endtask

  task automatic test_stack();
    int cyc;
    clear_img();
    img[0] = 8'h10; img[1] = 8'h04; img[2] = 8'h05; img[3] = 8'h09;
    run_program("push_pop", cyc);
    n_assert++;
    if (cyc !== 9 || wlog.size() !== 1 || dut.regs_q[13] !== 8'h00)
      begin n_fail++; $display("FAIL push_pop_const: cyc %0d writes %0d SP %h want 9 1 00", cyc, wlog.size(), dut.regs_q[13]); end
    else begin
      n_assert++;
      if (wlog[0] !== 16'hff00) begin n_fail++; $display("FAIL push_addr: got %h want ff00", wlog[0]); end
    end
    clear_img();
    img[0] = 8'h18; img[1] = 8'h02; img[2] = 8'h09; img[8] = 8'h03;
    run_program("call_ret", cyc);
    n_assert++;
    if (cyc !== 9 || wlog.size() !== 1 || dut.regs_q[13] !== 8'h00)
      begin n_fail++; $display("FAIL call_ret_const: cyc %0d writes %0d SP %h want 9 1 00", cyc, wlog.size(), dut.regs_q[13]); end
    else begin
      n_assert++;
      if (wlog[0] !== 16'hff02) begin n_fail++; $display("FAIL call_push: got %h want ff02", wlog[0]); end
    end
  endtask

  task automatic test_branch();
    int cyc;
    logic [3:0] a, b;
    bit flip, flag;
    for (int k = 0; k < 4; k++) begin
      flip = 1'($urandom_range(0, 1));
      a = 4'($urandom_range(1, 14));
      case (k)
        0: b = a;
        1: b = 4'(a + 4'($urandom_range(1, 15)));
        2: b = 4'($urandom_range(0, int'(a) - 1));
        default: b = 4'($urandom_range(int'(a), 15));
      endcase
      flag = ((k == 0 || k == 2) ? 1'b1 : 1'b0) ^ flip;
      clear_img();
      img[0] = {4'h1, a}; img[1] = 8'h31; img[2] = {4'h1, b};
      img[3] = (k < 2) ? 8'hc1 : 8'hd1; img[4] = flip ? 8'h07 : 8'h00;
      img[5] = 8'h1a; img[6] = 8'h01; img[7] = 8'h08; img[8] = 8'h12; img[9] = 8'h09;
      img[10] = 8'h13; img[11] = 8'h09;
      run_program("branch", cyc);
      n_assert++;
      if (dut.regs_q[12][0] !== flag || dut.regs_q[0] !== (flag ? 8'd3 : 8'd2) || dbg_cnt !== (flag ? 0 : 1))
        begin n_fail++; $display("FAIL branch%0d a=%0d b=%0d: SR0 %b WR %h dbg %0d want %b %0d %0d",
                                 k, a, b, dut.regs_q[12][0], dut.regs_q[0], dbg_cnt, flag, flag ? 3 : 2, flag ? 0 : 1); end
    end
  endtask

  task automatic gen_random(input int len);
    logic [3:0] op, x;
    clear_img();
    for (int i = 0; i < len; i++) begin
      op = 4'($urandom_range(0, 15));
      x  = 4'($urandom_range(0, 15));
      if (op == 4'h0) begin
        case ($urandom_range(0, 4))
          0: x = 4'h0; 1: x = 4'h4; 2: x = 4'h5; 3: x = 4'h7; default: x = 4'h8;
        endcase
      end
      if ((op == 4'h3 || op == 4'h9) && x == 4'he) x = 4'h1;
      img[i] = {op, x};
    end
    img[len] = 8'h09;
  endtask

  task automatic test_random();
    int cyc;
    for (int p = 0; p < 8; p++) begin
      for (int t = 0; t < 100; t++) begin
        gen_random(30);
        for (int i = 0; i < 256; i++) m_mem[i] = img[i];
        m_len = 30;
        model_run();
        if (m_clean) break;
      end
      run_program("random", cyc);
    end
  endtask

  task automatic wait_write(input string name, input logic [15:0] want);
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (mem_if.write_en) seen = 1;
    end
    n_assert++;
    if (!seen || {mem_if.addr, mem_if.data_out} !== want)
      begin n_fail++; $display("FAIL %s: seen %b got %h want %h", name, seen, {mem_if.addr, mem_if.data_out}, want); end
  endtask

  task automatic pulse_int0();
    @(posedge clk); #1 ext_int = 4'h1;
    @(posedge clk); #1 ext_int = 4'h0;
  endtask

  task automatic test_interrupt();
    clear_img();
    img[0] = 8'h16; img[1] = 8'h07; img[2] = 8'h01; img[4] = 8'h08; img[5] = 8'h06;
    img[6] = 8'h14; img[7] = 8'h31; img[8] = 8'h11; img[9] = 8'ha1; img[10] = 8'h3c;
    img[11] = 8'h07; img[12] = 8'h1d; img[13] = 8'h01;
    start_dut();
    repeat (40) @(posedge clk);
    for (int n = 0; n < 2; n++) begin
      pulse_int0();
      wait_write("int_push", 16'hff0d);
      @(posedge clk); #1;
      n_assert++;
      if (dut.regs_q[14] !== 8'd4 || dut.in_isr_q !== 1'b1)
        begin n_fail++; $display("FAIL int_entry%0d: PC %h in_isr %b want 04 1", n, dut.regs_q[14], dut.in_isr_q); end
      repeat (20) @(posedge clk);
      #1;
      n_assert++;
      if (dut.in_isr_q !== 1'b0 || dut.regs_q[14] !== 8'd13 || dut.regs_q[13] !== 8'd0 || dbg_cnt !== n + 1)
        begin n_fail++; $display("FAIL int_return%0d: in_isr %b PC %h SP %h dbg %0d want 0 0d 00 %0d",
                                 n, dut.in_isr_q, dut.regs_q[14], dut.regs_q[13], dbg_cnt, n + 1); end
    end
  endtask

  task automatic test_enable();
    int bad_we = 0;
    @(posedge clk); #1 enable = 1'b0;
    pulse_int0();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_if.write_en !== 1'b0) bad_we++;
    end
    n_assert++;
    if (bad_we !== 0 || wlog.size() !== 2 || dut.pending_q[0] !== 1'b1 || dut.in_isr_q !== 1'b0
        || dut.regs_q[14] !== 8'd13 || dut.regs_q[0] !== 8'd13)
      begin n_fail++; $display("FAIL frozen: we %0d writes %0d pend %b isr %b PC %h WR %h want 0 2 1 0 0d 0d",
                               bad_we, wlog.size(), dut.pending_q[0], dut.in_isr_q, dut.regs_q[14], dut.regs_q[0]); end
    @(posedge clk); #1 enable = 1'b1;
    wait_write("resume_int", 16'hff0d);
    repeat (20) @(posedge clk);
    #1;
    n_assert++;
    if (dbg_cnt !== 3 || dut.in_isr_q !== 1'b0 || dut.regs_q[14] !== 8'd13)
      begin n_fail++; $display("FAIL resume: dbg %0d isr %b PC %h want 3 0 0d", dbg_cnt, dut.in_isr_q, dut.regs_q[14]); end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; ext_int = 4'h0;
    test_reset();
    test_arith();
    test_mem();
    test_stack();
    test_branch();
    test_random();
    test_interrupt();
    test_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
